// File: rtl/ifft8_unit_pkg.sv
// rtl/ifft8_unit_pkg.sv - shared constants, encodings and helpers for the 8-point IFFT unit
package ifft8_unit_pkg;

  localparam int DW      = 32;
  localparam int TW_FRAC = 14;
  localparam int TW_C    = 11585;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_LOAD   = 2'b01,
    OP_CALC   = 2'b10,
    OP_EXPORT = 2'b11
  } ifft_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CALC0  = 3'd2,
    ST_CALC1  = 3'd3,
    ST_CALC2  = 3'd4,
    ST_FULL   = 3'd5,
    ST_DONE   = 3'd6,
    ST_EXPORT = 3'd7
  } ifft_state_e;

  // Conjugate twiddles: 1, e^{j*pi/4}, +j, e^{j*3pi/4}
  typedef enum logic [1:0] {
    TW_ONE = 2'd0,
    TW_E1  = 2'd1,
    TW_J   = 2'd2,
    TW_E3  = 2'd3
  } tw_sel_e;

  localparam logic [5:0] ALU_IFFT_LOAD   = 6'h2c;
  localparam logic [5:0] ALU_IFFT_CAL    = 6'h2d;
  localparam logic [5:0] ALU_IFFT_EXPORT = 6'h2e;

  function automatic logic [2:0] bitrev3(input logic [2:0] i);
    return {i[0], i[1], i[2]};
  endfunction

endpackage

// File: rtl/ifft8_unit_if.sv
// rtl/ifft8_unit_if.sv - command/data bus between the core and the IFFT unit
interface ifft8_unit_if;
  logic                                    cmd_valid;
  logic [1:0]                              cmd_op;
  logic signed [ifft8_unit_pkg::DW-1:0]    din;
  logic                                    cmd_ready;
  logic signed [ifft8_unit_pkg::DW-1:0]    dout;
  logic                                    dout_valid;
  logic                                    done;
  logic                                    err;

  modport master (
    output cmd_valid, cmd_op, din,
    input  cmd_ready, dout, dout_valid, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, din,
    output cmd_ready, dout, dout_valid, done, err
  );
endinterface

// File: rtl/ifft8_unit_butterfly.sv
// rtl/ifft8_unit_butterfly.sv - combinational radix-2 butterfly with conjugate twiddle and 1/2 scaling
module ifft8_unit_butterfly
  import ifft8_unit_pkg::*;
(
  input  logic signed [DW-1:0] a_re,
  input  logic signed [DW-1:0] a_im,
  input  logic signed [DW-1:0] b_re,
  input  logic signed [DW-1:0] b_im,
  input  tw_sel_e              tw,
  output logic signed [DW-1:0] ao_re,
  output logic signed [DW-1:0] ao_im,
  output logic signed [DW-1:0] bo_re,
  output logic signed [DW-1:0] bo_im
);

  localparam logic signed [DW+15:0] TW_K = (DW+16)'(TW_C);

  logic signed [DW:0]   b_diff;
  logic signed [DW:0]   b_sum;
  logic signed [DW-1:0] r_re;
  logic signed [DW-1:0] r_im;
  logic signed [DW-1:0] t_re;
  logic signed [DW-1:0] t_im;

  always_comb begin
    // b * e^{j*pi/4} = ((re-im)*c, (re+im)*c); the 3pi/4 case reuses it rotated by +j
    b_diff = (DW+1)'(b_re) - (DW+1)'(b_im);
    b_sum  = (DW+1)'(b_re) + (DW+1)'(b_im);
    r_re   = DW'(((DW+16)'(b_diff) * TW_K) >>> TW_FRAC);
    r_im   = DW'(((DW+16)'(b_sum)  * TW_K) >>> TW_FRAC);

    t_re = b_re;
    t_im = b_im;
    case (tw)
      TW_E1: begin
        t_re = r_re;
        t_im = r_im;
      end
      TW_J: begin
        t_re = -b_im;
        t_im = b_re;
      end
      TW_E3: begin
        t_re = -r_im;
        t_im = r_re;
      end
      default: begin
      end
    endcase

    ao_re = DW'(((DW+1)'(a_re) + (DW+1)'(t_re)) >>> 1);
    ao_im = DW'(((DW+1)'(a_im) + (DW+1)'(t_im)) >>> 1);
    bo_re = DW'(((DW+1)'(a_re) - (DW+1)'(t_re)) >>> 1);
    bo_im = DW'(((DW+1)'(a_im) - (DW+1)'(t_im)) >>> 1);
  end

endmodule

// File: rtl/ifft8_unit.sv
// rtl/ifft8_unit.sv - 8-point radix-2 DIT inverse FFT coprocessor (load, 3-stage calc, export)
module ifft8_unit
  import ifft8_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  ifft8_unit_if.slave bus
);

  ifft_state_e state;
  ifft_state_e state_nxt;
  logic [3:0]  cnt;
  logic        do_load;
  logic        do_export;
  logic        bad;
  logic        calc_active;

  logic signed [DW-1:0] smp_re [8];
  logic signed [DW-1:0] smp_im [8];

  logic [2:0]           ia [4];
  logic [2:0]           ib [4];
  tw_sel_e              tw [4];
  logic signed [DW-1:0] ao_re [4];
  logic signed [DW-1:0] ao_im [4];
  logic signed [DW-1:0] bo_re [4];
  logic signed [DW-1:0] bo_im [4];

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    do_load       = 1'b0;
    do_export     = 1'b0;
    bad           = 1'b0;
    calc_active   = (state == ST_CALC0) || (state == ST_CALC1) || (state == ST_CALC2);
    bus.cmd_ready = !calc_active;
    unique case (state)
      ST_CALC0: state_nxt = ST_CALC1;
      ST_CALC1: state_nxt = ST_CALC2;
      ST_CALC2: state_nxt = ST_DONE;
      default: begin
        if (bus.cmd_valid) begin
          unique case (ifft_op_e'(bus.cmd_op))
            OP_NOP: begin
            end
            OP_LOAD: begin
              if (state == ST_IDLE || state == ST_LOAD) begin
                do_load   = 1'b1;
                state_nxt = (cnt == 4'd15) ? ST_FULL : ST_LOAD;
              end else begin
                bad = 1'b1;
              end
            end
            OP_CALC: begin
              if (state == ST_FULL) state_nxt = ST_CALC0;
              else                  bad = 1'b1;
            end
            OP_EXPORT: begin
              if (state == ST_DONE || state == ST_EXPORT) begin
                do_export = 1'b1;
                state_nxt = (cnt == 4'd15) ? ST_IDLE : ST_EXPORT;
              end else begin
                bad = 1'b1;
              end
            end
          endcase
        end
      end
    endcase
  end

  // Butterfly pairing per stage; spans are 1, 2, 4 over bit-reversed storage
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      ia[p] = 3'(2 * p);
      ib[p] = 3'(2 * p + 1);
      tw[p] = TW_ONE;
      if (state == ST_CALC1) begin
        ia[p] = 3'((p / 2) * 4 + (p % 2));
        ib[p] = 3'((p / 2) * 4 + (p % 2) + 2);
        tw[p] = (p % 2 == 1) ? TW_J : TW_ONE;
      end else if (state == ST_CALC2) begin
        ia[p] = 3'(p);
        ib[p] = 3'(p + 4);
        tw[p] = tw_sel_e'(2'(p));
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_bfly
    ifft8_unit_butterfly u_bfly (
      .a_re  (smp_re[ia[g]]),
      .a_im  (smp_im[ia[g]]),
      .b_re  (smp_re[ib[g]]),
      .b_im  (smp_im[ib[g]]),
      .tw    (tw[g]),
      .ao_re (ao_re[g]),
      .ao_im (ao_im[g]),
      .bo_re (bo_re[g]),
      .bo_im (bo_im[g])
    );
  end

  always_ff @(posedge clk) begin
    if (do_load) begin
      if (cnt[0]) smp_im[bitrev3(cnt[3:1])] <= bus.din;
      else        smp_re[bitrev3(cnt[3:1])] <= bus.din;
    end else if (calc_active) begin
      for (int p = 0; p < 4; p++) begin
        smp_re[ia[p]] <= ao_re[p];
        smp_im[ia[p]] <= ao_im[p];
        smp_re[ib[p]] <= bo_re[p];
        smp_im[ib[p]] <= bo_im[p];
      end
    end
  end

  // One counter serves both load and export; it wraps to 0 after the 16th word
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= 4'd0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      if (do_load || do_export) cnt <= cnt + 4'd1;
      if (do_export) bus.dout <= cnt[0] ? smp_im[cnt[3:1]] : smp_re[cnt[3:1]];
      bus.dout_valid <= do_export;
      bus.done       <= (state == ST_CALC2);
      bus.err        <= bad;
    end
  end

endmodule

// File: tb/tb_ifft8_unit.sv
// tb/tb_ifft8_unit.sv - randomized self-checking bench for ifft8_unit against a direct-DFT reference
module tb_ifft8_unit;
  import ifft8_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifft8_unit_if bus ();

  ifft8_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int  n_tests = 0;
  int  n_fail  = 0;
  int  xr [8];
  int  xi [8];
  int  yr [8];
  int  yi [8];
  real mr [8];
  real mi [8];

  task automatic check(input string tag, input longint got, input longint exp, input longint tol = 0);
    longint diff;
    n_tests++;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic longint rnd(input real r);
    if (r >= 0.0) return longint'($rtoi(r + 0.5));
    return -longint'($rtoi(-r + 0.5));
  endfunction

  // x[n] = 1/8 * sum_k X[k] * e^{+j*2*pi*k*n/8}, with cos(pi/4) taken as the quantised constant
  task automatic model();
    real c;
    real wr [8];
    real wi [8];
    real er;
    real ei;
    c  = real'(TW_C) / real'(1 << TW_FRAC);
    wr = '{1.0, c, 0.0, -c, -1.0, -c, 0.0, c};
    wi = '{0.0, c, 1.0, c, 0.0, -c, -1.0, -c};
    for (int n = 0; n < 8; n++) begin
      er = 0.0;
      ei = 0.0;
      for (int k = 0; k < 8; k++) begin
        er += real'(xr[k]) * wr[(k * n) % 8] - real'(xi[k]) * wi[(k * n) % 8];
        ei += real'(xr[k]) * wi[(k * n) % 8] + real'(xi[k]) * wr[(k * n) % 8];
      end
      mr[n] = er / 8.0;
      mi[n] = ei / 8.0;
    end
  endtask

  task automatic send(input logic [1:0] op, input int data, output logic e, output logic v, output int d);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.din       = data;
    @(posedge clk);
    #1;
    e = bus.err;
    v = bus.dout_valid;
    d = bus.dout;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic clear_frame();
    for (int k = 0; k < 8; k++) begin
      xr[k] = 0;
      xi[k] = 0;
    end
  endtask

  task automatic rand_frame();
    for (int k = 0; k < 8; k++) begin
      xr[k] = int'($urandom_range(0, 2097152)) - 1048576;
      xi[k] = int'($urandom_range(0, 2097152)) - 1048576;
    end
  endtask

  task automatic load_words(input string tag, input int from, input int to);
    logic e, v;
    int d, errs;
    errs = 0;
    for (int w = from; w < to; w++) begin
      send(OP_LOAD, w[0] ? xi[w >> 1] : xr[w >> 1], e, v, d);
      errs += int'(e);
    end
    check({tag, " load err"}, errs, 0);
  endtask

  task automatic calc_and_wait(input string tag);
    logic e, v;
    int d, lat;
    send(OP_CALC, 0, e, v, d);
    check({tag, " calc err"}, e, 0);
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = i + 1;
        break;
      end
    end
    check({tag, " done latency"}, lat, 4);
    if (lat > 0) begin
      @(posedge clk);
      #1;
      check({tag, " done pulse width"}, bus.done, 0);
    end
  endtask

  task automatic export_and_check(input string tag, input int tol);
    logic e, v;
    int d, errs, pulses;
    errs   = 0;
    pulses = 0;
    for (int w = 0; w < 16; w++) begin
      send(OP_EXPORT, 0, e, v, d);
      errs   += int'(e);
      pulses += int'(v);
      if (w[0]) yi[w >> 1] = d;
      else      yr[w >> 1] = d;
    end
    check({tag, " dout_valid pulses"}, pulses, 16);
    check({tag, " export err"}, errs, 0);
    model();
    for (int n = 0; n < 8; n++) begin
      check($sformatf("%s x%0d re", tag, n), yr[n], rnd(mr[n]), tol);
      check($sformatf("%s x%0d im", tag, n), yi[n], rnd(mi[n]), tol);
    end
  endtask

  task automatic run_frame(input string tag, input int tol);
    load_words(tag, 0, 16);
    calc_and_wait(tag);
    export_and_check(tag, tol);
  endtask

  initial begin
    logic e, v;
    int d, busy, dones;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.din       = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset dout", bus.dout, 0);
    check("reset dout_valid", bus.dout_valid, 0);
    check("reset done", bus.done, 0);
    check("reset err", bus.err, 0);
    check("reset cmd_ready", bus.cmd_ready, 1);
    rst = 1'b0;

    clear_frame();
    xr[0] = 8;
    run_frame("impulse", 0);
    for (int n = 0; n < 8; n++) begin
      check($sformatf("impulse const x%0d re", n), yr[n], 1);
      check($sformatf("impulse const x%0d im", n), yi[n], 0);
    end

    for (int k = 0; k < 8; k++) begin
      xr[k] = 800;
      xi[k] = 0;
    end
    run_frame("dc", 0);
    check("dc x0 re", yr[0], 800);

    clear_frame();
    xr[1] = 8192;
    run_frame("tone", 4);
    check("tone ideal x0 re", yr[0], 1024, 2);
    check("tone ideal x0 im", yi[0], 0, 2);
    check("tone ideal x1 re", yr[1], 724, 2);
    check("tone ideal x1 im", yi[1], 724, 2);
    check("tone ideal x2 re", yr[2], 0, 2);
    check("tone ideal x2 im", yi[2], 1024, 2);
    check("tone ideal x4 re", yr[4], -1024, 2);
    check("tone ideal x4 im", yi[4], 0, 2);

    send(OP_EXPORT, 0, e, v, d);
    check("export in idle err", e, 1);
    check("export in idle dout_valid", v, 0);
    send(OP_NOP, 0, e, v, d);
    check("nop err", e, 0);

    rand_frame();
    load_words("partial", 0, 10);
    send(OP_CALC, 0, e, v, d);
    check("calc in load err", e, 1);
    load_words("partial", 10, 16);
    calc_and_wait("partial");
    export_and_check("partial", 4);

    rand_frame();
    load_words("bp", 0, 16);
    send(OP_CALC, 0, e, v, d);
    check("bp calc err", e, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_LOAD;
    bus.din       = 32'sd12345;
    busy = 0;
    for (int i = 0; i < 8 && !bus.cmd_ready; i++) begin
      @(posedge clk);
      #1;
      busy++;
    end
    check("bp busy cycles", busy, 3);
    check("bp done at ready", bus.done, 1);
    @(posedge clk);
    #1;
    check("bp load in done err", bus.err, 1);
    check("bp load in done dout_valid", bus.dout_valid, 0);
    bus.cmd_valid = 1'b0;
    export_and_check("bp", 4);

    for (int r = 0; r < 4; r++) begin
      rand_frame();
      run_frame($sformatf("rand%0d", r), 4);
    end

    clear_frame();
    xr[0] = 8;
    load_words("rst", 0, 16);
    send(OP_CALC, 0, e, v, d);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst mid calc cmd_ready", bus.cmd_ready, 1);
    dones = int'(bus.done);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      dones += int'(bus.done);
    end
    check("rst mid calc done pulses", dones, 0);
    send(OP_EXPORT, 0, e, v, d);
    check("rst then export err", e, 1);
    run_frame("impulse again", 0);
    for (int n = 0; n < 8; n++) begin
      check($sformatf("impulse again const x%0d re", n), yr[n], 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ifft8_unit.md
Name: ifft8_unit

Overview:
- 8-point radix-2 inverse FFT coprocessor. It is the inverse-direction counterpart of the ALU's FFT load/calc/export path.
- The core issues custom-instruction commands. It streams 16 words in (X[k] real/imag interleaved), triggers a 3-stage compute, then streams 16 words out (x[n] real/imag interleaved).
- Sits beside the ALU. Its dout is muxed into alu_result for IFFT export instructions.

Parameters:
- DW, 32, data word width (matches `instWidth)
- TW_FRAC, 14, fractional bits of the twiddle constant
- TW_C, 11585, round(cos(pi/4)·2^TW_FRAC)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_op  in  2  00 NOP, 01 LOAD, 10 CALC, 11 EXPORT
- din  in  DW  signed load word (used on LOAD)
- cmd_ready  out  1  command accepted this cycle when cmd_valid&&cmd_ready
- dout  out  DW  signed export word
- dout_valid  out  1  one-cycle pulse, dout valid
- done  out  1  one-cycle pulse, compute finished
- err  out  1  one-cycle pulse, illegal command dropped

Behaviour:
- Reset values:
  - dout=0, dout_valid=0, done=0, err=0, cmd_ready=1.
  - State IDLE, load/export counters 0.
  - Sample buffer contents are don't-care.
  - rst in any state, including mid-CALC or mid-EXPORT, aborts to IDLE on the next edge.
- States: IDLE, LOAD, CALC0, CALC1, CALC2, FULL, DONE, EXPORT.
- LOAD handling:
  - Accepted LOAD in IDLE/LOAD writes din to slot cnt, then cnt++.
  - Even cnt = real part, odd cnt = imag part of X[cnt/2].
  - Storage is at bit-reversed index (DIT ordering).
  - When cnt reaches 16 → FULL.
- CALC handling:
  - Accepted CALC in FULL → CALC0.
  - Stages run on consecutive edges CALC0→CALC1→CALC2→DONE.
  - cmd_ready=0 in CALC0..CALC2.
  - done=1 for the single cycle after the CALC2 edge. Latency from CALC accept to done is 4 cycles.
- EXPORT handling:
  - Accepted EXPORT in DONE/EXPORT: next cycle dout = word ecnt (x[ecnt/2] re/im, natural order), dout_valid=1, then ecnt++.
  - After the 16th word → IDLE, counters cleared.
- Illegal commands:
  - Any other accepted op/state pair is dropped, state unchanged, err=1 the next cycle.
  - Examples: CALC in IDLE/LOAD, LOAD in FULL/DONE/EXPORT, EXPORT before DONE.
  - NOP is always legal and has no effect.
- Butterfly (per stage, all 4 pairs in parallel):
  - t=W·b
  - a'=(a+t)>>>1, b'=(a−t)>>>1
  - Sums formed at DW+1 bits, arithmetic shift, result truncated to DW.
  - Total scaling is 1/8, as the IFFT requires.
- Twiddles, conjugate (IFFT) direction, W=e^{+j2πk/8}:
  - Stage0: W=1.
  - Stage1: W∈{1, +j}.
  - Stage2: W∈{1, e^{jπ/4}, +j, e^{j3π/4}}.
- Twiddle arithmetic:
  - ·j is exact: (re,im)→(−im,re).
  - e^{jπ/4}: re=((re−im)·TW_C)>>>TW_FRAC, im=((re+im)·TW_C)>>>TW_FRAC. Differences at DW+1 bits, product at DW+16 bits, truncate.
  - e^{j3π/4} = j·e^{jπ/4}.
- Overflow wraps; no saturation.
- Simultaneous events: cmd_valid while cmd_ready=0 is not accepted, with no err. The caller must hold it.

Decomposition:
- Shared define.v:
  - IFFT opcode values (cmd_op encodings).
  - State encodings.
  - TW_C/TW_FRAC constants.
  - aluIFFTLoad/aluIFFTCal/aluIFFTExport ALU opcodes.
- One combinational sub-module ifft_butterfly:
  - Inputs a, b, twiddle select (2 bits).
  - Outputs a', b' with the width rules above.
  - Instantiated 4×, operands muxed by stage.

Test Plan:
- Impulse: load X0=(8,0), all others 0, then CALC, then 16 EXPORTs → every x[n]=(1,0); done 4 cycles after CALC accept; 16 dout_valid pulses.
- DC input: all X[k]=(800,0) → x0=(800,0), x1..x7=(0,0).
- Single tone: X1=(8192,0), rest 0 → x[n]≈1024·e^{j2πn/8}. Expected x0=(1024,0), x1≈(724,724), x2=(0,1024), x4=(−1024,0), each within ±2 LSB.
- Illegal ops:
  - EXPORT in IDLE → err pulse, no dout_valid.
  - CALC after 10 LOADs → err, state stays LOAD; 6 more LOADs then CALC succeeds.
- Backpressure: CALC accepted, then LOAD held valid → cmd_ready=0 for 3 cycles. LOAD is taken in DONE and raises err.
- Reset mid-op: rst asserted during CALC1 → next cycle IDLE, cmd_ready=1, done never pulses. A fresh impulse run then matches the first test.
